// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//
// Control unit for a 5-stage RISC-V pipeline. It decodes the ID-stage
// opcode into control bits and carries them through the ID/EX, EX/MEM and
// MEM/WB pipeline registers. It also injects bubbles (flush/stall) and
// computes the EX-stage PC redirect.
//
// Handshake: there is no valid/ready pair. valid_d qualifies the ID
// instruction each cycle. A stage holding a bubble carries all-zero control,
// so it never writes the register file or memory.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   opcode_d          instr[6:0] of the instruction in ID
//   valid_d           ID instruction is real (0 = bubble)
//   flush_e           load a bubble into ID/EX (wins over stall_e)
//   stall_e           hold ID/EX and push a bubble into EX/MEM
//   zero_e            ALU zero / branch-taken flag from EX
//   imm_src_d         immediate format select (combinational)
//   illegal_d         valid_d & unsupported opcode (combinational)
//   alu_op_e, alu_src_a_e, alu_src_b_e, branch_e, jump_e, jalr_e,
//   illegal_e         registered EX-stage control
//   pc_src_e          redirect the fetch PC
//   reg_write_{e,m,w}, result_src_{e,m,w}, mem_write_{e,m}
//                     per-stage writeback and memory control
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter bit ENABLE_JALR  = 1'b1,
    parameter bit ENABLE_UTYPE = 1'b1,
    parameter int IMM_SRC_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode_d,
    input  logic                 valid_d,
    input  logic                 flush_e,
    input  logic                 stall_e,
    input  logic                 zero_e,
    output logic [IMM_SRC_W-1:0] imm_src_d,
    output logic                 illegal_d,
    output logic [1:0]           alu_op_e,
    output logic [1:0]           alu_src_a_e,
    output logic [1:0]           alu_src_b_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic                 pc_src_e,
    output logic                 illegal_e,
    output logic                 reg_write_e,
    output logic                 reg_write_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_e,
    output logic [1:0]           result_src_m,
    output logic [1:0]           result_src_w,
    output logic                 mem_write_e,
    output logic                 mem_write_m
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

    ctrl_t     dec;
    logic [2:0] imm3;
    logic       unsupported;

    ctrl_t     id_ex;
    mem_ctrl_t ex_mem;
    wb_ctrl_t  mem_wb;

    // ---------------- ID-stage decode ----------------
    always_comb begin
        dec         = '0;
        imm3        = 3'b000;
        unsupported = 1'b0;
        case (opcode_d)
            7'b0000011: begin // load
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 2'b01;
                dec.result_src = 2'b01;
            end
            7'b0100011: begin // store
                imm3          = 3'b001;
                dec.alu_src_b = 2'b01;
                dec.mem_write = 1'b1;
            end
            7'b0110011: begin // R-type
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
            end
            7'b1100011: begin // branch
                imm3       = 3'b010;
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
            end
            7'b0010011: begin // I-type ALU
                dec.reg_write = 1'b1;
                dec.alu_src_b = 2'b01;
                dec.alu_op    = 2'b10;
            end
            7'b1101111: begin // JAL
                imm3           = 3'b011;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
            end
            7'b1100111: begin // JALR
                if (ENABLE_JALR) begin
                    dec.reg_write  = 1'b1;
                    dec.alu_src_b  = 2'b01;
                    dec.result_src = 2'b10;
                    dec.jump       = 1'b1;
                    dec.jalr       = 1'b1;
                end else begin
                    unsupported = 1'b1;
                end
            end
            7'b0110111: begin // LUI: zero + imm
                if (ENABLE_UTYPE) begin
                    imm3          = 3'b100;
                    dec.reg_write = 1'b1;
                    dec.alu_src_a = 2'b10;
                    dec.alu_src_b = 2'b01;
                end else begin
                    unsupported = 1'b1;
                end
            end
            7'b0010111: begin // AUIPC: PC + imm
                if (ENABLE_UTYPE) begin
                    imm3          = 3'b100;
                    dec.reg_write = 1'b1;
                    dec.alu_src_a = 2'b01;
                    dec.alu_src_b = 2'b01;
                end else begin
                    unsupported = 1'b1;
                end
            end
            default: unsupported = 1'b1;
        endcase

        // A bubble clears every control field. imm3 is kept so that
        // immediate extension stays deterministic.
        if (!valid_d) begin
            dec = '0;
        end
        dec.illegal = valid_d & unsupported;
    end

    assign imm_src_d = IMM_SRC_W'(imm3);
    assign illegal_d = dec.illegal;

    // ---------------- ID/EX: flush > stall > load ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex <= '0;
        end else if (flush_e) begin
            id_ex <= '0;
        end else if (!stall_e) begin
            id_ex <= dec;
        end
    end

    // ---------------- EX/MEM: bubble only on stall without flush --------
    // When flush and stall are both high, the EX instruction still moves on
    // to MEM, because ID/EX is being cleared rather than held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem <= '0;
        end else if (stall_e && !flush_e) begin
            ex_mem <= '0;
        end else begin
            ex_mem <= '{reg_write:  id_ex.reg_write,
                        result_src: id_ex.result_src,
                        mem_write:  id_ex.mem_write};
        end
    end

    // ---------------- MEM/WB: always advances ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb <= '0;
        end else begin
            mem_wb <= '{reg_write:  ex_mem.reg_write,
                        result_src: ex_mem.result_src};
        end
    end

    assign alu_op_e     = id_ex.alu_op;
    assign alu_src_a_e  = id_ex.alu_src_a;
    assign alu_src_b_e  = id_ex.alu_src_b;
    assign branch_e     = id_ex.branch;
    assign jump_e       = id_ex.jump;
    assign jalr_e       = id_ex.jalr;
    assign illegal_e    = id_ex.illegal;
    assign reg_write_e  = id_ex.reg_write;
    assign result_src_e = id_ex.result_src;
    assign mem_write_e  = id_ex.mem_write;
    assign pc_src_e     = id_ex.jump | (id_ex.branch & zero_e);

    assign reg_write_m  = ex_mem.reg_write;
    assign result_src_m = ex_mem.result_src;
    assign mem_write_m  = ex_mem.mem_write;

    assign reg_write_w  = mem_wb.reg_write;
    assign result_src_w = mem_wb.result_src;

endmodule
